ref_fetch: RTL and testbench

- Responder side of the previous-frame pixel request interface: accepts pixel requests (mx, my, mreq), returns pixels in order (m_valid, m_px), and applies m_wait backpressure.
- Turns each request into a frame-memory byte read at (base_x+mx, base_y+my).
- Sits between the motion-estimation block comparator and the frame-memory read master.

---
 rtl/mpeg2_pkg.sv | 16 +
 rtl/ref_fetch_cmdq.sv | 70 +++++++
 rtl/ref_fetch.sv | 136 +++++++++++++
 tb/tb_ref_fetch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg2_pkg.sv
// Shared MPEG-2 motion-estimation definitions.
// Holds the frame geometry used to turn pixel coordinates into frame-memory
// byte addresses, plus the coordinate and pixel types shared by the blocks.
package mpeg2_pkg;

  localparam int FRAME_W     = 352;  // visible frame width in pixels
  localparam int FRAME_H     = 288;  // visible frame height in pixels
  localparam int STRIDE_LOG2 = 9;    // line stride is 512 bytes
  localparam int FRAME_BASE  = 0;    // byte address of pixel (0,0)
  localparam int COORD_W     = 12;
  localparam int PIX_W       = 8;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0]          pixel_t;

endpackage

// File: rtl/ref_fetch_cmdq.sv
// Command queue for ref_fetch: synchronous FIFO of memory byte addresses.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (clears pointers/count)
//   push, push_data write one entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head            current head entry
//   count           number of entries held (0..DEPTH)
//   full, empty     count == DEPTH, count == 0
module ref_fetch_cmdq #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; validity comes from count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ref_fetch.sv
// Previous-frame pixel fetch (responder side of the pixel request interface).
// Each accepted request (mx,my) becomes a byte read of frame memory at
// (base_x+mx, base_y+my); pixels come back in request order on m_valid/m_px.
// Build option: define REF_FETCH_CLAMP_EN to clamp coordinates into the
// visible frame (edge-pixel replication); otherwise raw sums form the address.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, base_x, base_y      load search-window origin (only when idle)
//   mx, my, mreq               pixel request, accepted when m_wait=0
//   m_wait                     command queue full, no request taken
//   m_valid, m_px              returned pixel, one-cycle pulse
//   busy                       queue, reads in flight or return pending
//   mem_addr, mem_read         read master command
//   mem_waitrequest            memory stall, command held
//   mem_readdata, mem_readdatavalid  in-order read return
module ref_fetch
  import mpeg2_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int CMD_DEPTH = 4,
  parameter int MAX_OUT   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  coord_t            base_x,
  input  coord_t            base_y,
  input  logic [3:0]        mx,
  input  logic [3:0]        my,
  input  logic              mreq,
  output logic              m_wait,
  output logic              m_valid,
  output pixel_t            m_px,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  pixel_t            mem_readdata,
  input  logic              mem_readdatavalid
);

  localparam int CW = $clog2(CMD_DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);

  coord_t            base_x_q, base_x_d, base_y_q, base_y_d;
  logic [OW-1:0]     out_q, out_d;
  logic              m_valid_q, m_valid_d;
  pixel_t            m_px_q, m_px_d;

  coord_t            x_raw, y_raw, x_c, y_c;
  logic [ADDR_W-1:0] x_ext, y_ext, addr;
  logic              load, push, pop, rdv_ok;
  logic              q_full, q_empty;
  logic [CW:0]       q_count;
  logic [ADDR_W-1:0] q_head;

`ifdef REF_FETCH_CLAMP_EN
  function automatic coord_t clamp_coord(coord_t v, coord_t hi);
    if (v < coord_t'(0)) return '0;
    if (v > hi)          return hi;
    return v;
  endfunction
`endif

  assign busy     = (q_count != '0) || (out_q != '0) || m_valid_q;
  assign m_wait   = q_full;
  assign load     = start && !busy;
  assign push     = mreq && !m_wait;
  assign mem_read = !q_empty && (out_q < OW'(MAX_OUT));
  assign pop      = mem_read && !mem_waitrequest;
  assign mem_addr = mem_read ? q_head : '0;
  // Returns with nothing outstanding belong to reads discarded by reset.
  assign rdv_ok   = mem_readdatavalid && (out_q != '0);
  assign m_valid  = m_valid_q;
  assign m_px     = m_px_q;

  always_comb begin
    base_x_d = load ? base_x : base_x_q;
    base_y_d = load ? base_y : base_y_q;

    // A request accepted alongside start already sees the new origin.
    x_raw = base_x_d + coord_t'({8'b0, mx});
    y_raw = base_y_d + coord_t'({8'b0, my});
`ifdef REF_FETCH_CLAMP_EN
    x_c = clamp_coord(x_raw, coord_t'(FRAME_W - 1));
    y_c = clamp_coord(y_raw, coord_t'(FRAME_H - 1));
`else
    x_c = x_raw;
    y_c = y_raw;
`endif
    x_ext = {{(ADDR_W-COORD_W){x_c[COORD_W-1]}}, x_c};
    y_ext = {{(ADDR_W-COORD_W){y_c[COORD_W-1]}}, y_c};
    addr  = ADDR_W'(FRAME_BASE) + (y_ext << STRIDE_LOG2) + x_ext;

    unique case ({pop, rdv_ok})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    m_valid_d = rdv_ok;
    m_px_d    = rdv_ok ? mem_readdata : m_px_q;
  end

  ref_fetch_cmdq #(
    .W     (ADDR_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmdq (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (addr),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_x_q  <= '0;
      base_y_q  <= '0;
      out_q     <= '0;
      m_valid_q <= 1'b0;
      m_px_q    <= '0;
    end else begin
      base_x_q  <= base_x_d;
      base_y_q  <= base_y_d;
      out_q     <= out_d;
      m_valid_q <= m_valid_d;
      m_px_q    <= m_px_d;
    end
  end

endmodule

// File: tb/tb_ref_fetch.sv
// Directed bench for ref_fetch with an in-order frame-memory model whose
// read latency is programmable; memory data is a fixed hash of the address.
module tb_ref_fetch;
  import mpeg2_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [11:0] base_x, base_y;
  logic [3:0]         mx, my;
  logic               mreq;
  logic               m_wait, m_valid, busy, mem_read;
  logic [7:0]         m_px;
  logic [19:0]        mem_addr;
  logic               mem_waitrequest;
  logic [7:0]         mem_readdata = 8'h00;
  logic               mem_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  ref_fetch dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_x            (base_x),
    .base_y            (base_y),
    .mx                (mx),
    .my                (my),
    .mreq              (mreq),
    .m_wait            (m_wait),
    .m_valid           (m_valid),
    .m_px              (m_px),
    .busy              (busy),
    .mem_addr          (mem_addr),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid)
  );

  typedef struct {
    logic [19:0] a;
    int          due;
  } rd_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat   = 1;
  int          tick  = 0;
  int          vld_cnt = 0;
  rd_t         mem_q[$];
  logic [19:0] eaddr_q[$];
  logic [7:0]  epx_q[$];

`ifdef REF_FETCH_CLAMP_EN
  localparam logic [19:0] A_NEG = 20'd0;
  localparam logic [19:0] A_BIG = 20'd147295;
`else
  localparam logic [19:0] A_NEG = 20'd1046524;
  localparam logic [19:0] A_BIG = 20'd154477;
`endif

  function automatic logic [7:0] pix(logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]};
  endfunction

  function automatic logic [19:0] addr_of(int bx, int by, int ox, int oy);
    int x, y, lin;
    x = bx + ox;
    y = by + oy;
`ifdef REF_FETCH_CLAMP_EN
    if (x < 0)   x = 0;
    if (x > 351) x = 351;
    if (y < 0)   y = 0;
    if (y > 287) y = 287;
`endif
    lin = y * 512 + x;
    return lin[19:0];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic accept(int bx, int by, int ox, int oy);
    logic [19:0] a;
    a = addr_of(bx, by, ox, oy);
    eaddr_q.push_back(a);
    epx_q.push_back(pix(a));
  endtask

  // Memory model and return monitor, evaluated mid-cycle.
  task automatic mem_tick();
    rd_t r;
    tick++;
    if (mem_read && !mem_waitrequest) begin
      check("read_pending", 32'(eaddr_q.size() != 0), 32'd1);
      if (eaddr_q.size() != 0) check("read_addr", 32'(mem_addr), 32'(eaddr_q.pop_front()));
      r.a   = mem_addr;
      r.due = tick + lat;
      mem_q.push_back(r);
    end
    if (mem_q.size() != 0 && mem_q[0].due <= tick) begin
      r = mem_q.pop_front();
      mem_readdatavalid = 1'b1;
      mem_readdata      = pix(r.a);
    end else begin
      mem_readdatavalid = 1'b0;
    end
    if (m_valid) begin
      vld_cnt++;
      check("ret_pending", 32'(epx_q.size() != 0), 32'd1);
      if (epx_q.size() != 0) check("ret_px", 32'(m_px), 32'(epx_q.pop_front()));
    end
  endtask

  task automatic step();
    @(negedge clk);
    mem_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 200 && busy; i++) step();
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_m_wait"},   32'(m_wait),   32'd0);
    check({tag, "_m_valid"},  32'(m_valid),  32'd0);
    check({tag, "_m_px"},     32'(m_px),     32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
  endtask

  initial begin
    int  idx, wcnt, lv, maxif;
    bit  wr_done, saw_wait, saw8;

    reset = 1'b1; start = 1'b0; base_x = '0; base_y = '0;
    mx = '0; my = '0; mreq = 1'b0; mem_waitrequest = 1'b0;
    step(); step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Single request, 1-cycle memory.
    start = 1'b1; base_x = 12'sd16; base_y = 12'sd32; mx = 4'd3; my = 4'd2; mreq = 1'b1;
    check("t1_m_wait", 32'(m_wait), 32'd0);
    accept(16, 32, 3, 2);
    step();
    start = 1'b0; mreq = 1'b0;
    check("t1_mem_read", 32'(mem_read), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'd17427);
    step();
    check("t1_no_valid_yet", 32'(m_valid), 32'd0);
    step();
    check("t1_m_valid", 32'(m_valid), 32'd1);
    check("t1_m_px", 32'(m_px), 32'h57);
    check("t1_busy_hi", 32'(busy), 32'd1);
    step();
    check("t1_busy_lo", 32'(busy), 32'd0);

    // start while busy is ignored.
    mx = 4'd1; my = 4'd1; mreq = 1'b1;
    accept(16, 32, 1, 1);
    step();
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_addr_a", 32'(mem_addr), 32'd16913);
    start = 1'b1; base_x = 12'sd100; base_y = 12'sd100; mx = 4'd0; my = 4'd0; mreq = 1'b1;
    accept(16, 32, 0, 0);
    step();
    start = 1'b0; mreq = 1'b0;
    check("t6_addr_b", 32'(mem_addr), 32'd16400);
    wait_idle("t6_idle");

    // 256 back-to-back requests with a 10-cycle stall at request 3.
    vld_cnt = 0; idx = 0; wcnt = 0; wr_done = 0; saw_wait = 0;
    for (int c = 0; c < 2000 && idx < 256; c++) begin
      if (idx == 3 && !wr_done) begin wcnt = 10; wr_done = 1; end
      mem_waitrequest = (wcnt > 0);
      if (wcnt == 1) begin
        check("t2_stall_read", 32'(mem_read), 32'd1);
        check("t2_stall_addr", 32'(mem_addr), 32'd16402);
        check("t2_stall_wait", 32'(m_wait), 32'd1);
      end
      if (wcnt > 0) wcnt--;
      mx = 4'(idx); my = 4'(idx >> 4); mreq = 1'b1;
      if (m_wait) saw_wait = 1;
      else begin
        accept(16, 32, idx % 16, idx / 16);
        idx++;
      end
      step();
    end
    mreq = 1'b0; mem_waitrequest = 1'b0;
    check("t2_accepted", 32'(idx), 32'd256);
    check("t2_wait_seen", 32'(saw_wait), 32'd1);
    for (int c = 0; c < 600 && vld_cnt < 256; c++) step();
    check("t2_returns", 32'(vld_cnt), 32'd256);
    check("t2_exp_drained", 32'(epx_q.size()), 32'd0);
    wait_idle("t2_idle");

    // Long latency: throttle at MAX_OUT reads in flight.
    lat = 12; idx = 0; lv = 0; maxif = 0; saw8 = 0;
    for (int c = 0; c < 400; c++) begin
      if (m_valid) lv++;
      if (lv == 12) break;
      if (mem_q.size() > maxif) maxif = mem_q.size();
      if (mem_q.size() == 8) begin
        saw8 = 1;
        check("t3_hold_at_max", 32'(mem_read), 32'd0);
      end
      mreq = (idx < 12); mx = 4'(idx); my = 4'd0;
      if (mreq && !m_wait) begin
        accept(16, 32, idx, 0);
        idx++;
      end
      step();
    end
    mreq = 1'b0;
    check("t3_returns", 32'(lv), 32'd12);
    check("t3_saw_max", 32'(saw8), 32'd1);
    check("t3_max_inflight", 32'(maxif), 32'd8);
    check("t3_busy_last_valid", 32'(busy), 32'd1);
    step();
    check("t3_busy_after", 32'(busy), 32'd0);

    // Out-of-frame coordinates.
    lat = 1;
    wait_idle("t4_idle0");
    start = 1'b1; base_x = -12'sd4; base_y = -12'sd4; mx = 4'd0; my = 4'd0; mreq = 1'b1;
    accept(-4, -4, 0, 0);
    step();
    start = 1'b0; mreq = 1'b0;
    check("t4_addr_neg", 32'(mem_addr), 32'(A_NEG));
    wait_idle("t4_idle1");
    start = 1'b1; base_x = 12'sd350; base_y = 12'sd286; mx = 4'd15; my = 4'd15; mreq = 1'b1;
    accept(350, 286, 15, 15);
    step();
    start = 1'b0; mreq = 1'b0;
    check("t4_addr_big", 32'(mem_addr), 32'(A_BIG));
    wait_idle("t4_idle2");

    // Reset with three reads in flight.
    lat = 12;
    for (int i = 0; i < 3; i++) begin
      mx = 4'(i); my = 4'd0; mreq = 1'b1;
      accept(350, 286, i, 0);
      step();
    end
    mreq = 1'b0;
    for (int i = 0; i < 10 && mem_q.size() != 3; i++) step();
    check("t5_inflight", 32'(mem_q.size()), 32'd3);
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    eaddr_q.delete();
    epx_q.delete();
    step();
    reset = 1'b0;
    lv = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_valid) lv++;
      step();
    end
    check("t5_late_no_valid", 32'(lv), 32'd0);
    check("t5_mem_drained", 32'(mem_q.size()), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    lat = 1;
    mx = 4'd5; my = 4'd5; mreq = 1'b1;
    accept(0, 0, 5, 5);
    step();
    mreq = 1'b0;
    check("t5_new_addr", 32'(mem_addr), 32'd2565);
    step();
    step();
    check("t5_new_valid", 32'(m_valid), 32'd1);
    check("t5_new_px", 32'(m_px), 32'h0F);
    step();
    check("t5_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
